lu_serial_arbiter: RTL and testbench



---
 rtl/lu_pkg.sv | 15 +
 rtl/lu_serial_arbiter_if.sv | 36 +++
 rtl/lu_bit_cell.sv | 21 ++
 rtl/lu_serial_arbiter.sv | 133 +++++++++++++
 tb/tb_lu_serial_arbiter.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/lu_pkg.sv
// Shared op codes and FSM state encoding for the serial logic-unit arbiter.
package lu_pkg;

   localparam logic [1:0] LU_NOR  = 2'b00;
   localparam logic [1:0] LU_OR   = 2'b01;
   localparam logic [1:0] LU_XNOR = 2'b10;
   localparam logic [1:0] LU_XOR  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/lu_serial_arbiter_if.sv
// Requester/response handshake bundle between the operand sources and the arbiter.
interface lu_serial_arbiter_if #(
   parameter int WIDTH = 8
) ();

   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic [1:0]       req0_op;
   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic [1:0]       req1_op;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_id;
   logic             busy;

   modport master (
      output req0_valid, req0_a, req0_b, req0_op,
      output req1_valid, req1_a, req1_b, req1_op,
      output rsp_ready,
      input  req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, busy
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op,
      input  req1_valid, req1_a, req1_b, req1_op,
      input  rsp_ready,
      output req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, busy
   );

endinterface

// File: rtl/lu_bit_cell.sv
// One-bit logic cell: op[1] picks XOR vs OR family, op[0] picks true vs inverted.
module lu_bit_cell
   import lu_pkg::*;
(
   input  logic       i_a,
   input  logic       i_b,
   input  logic [1:0] i_op,
   output logic       o_y
);

   always_comb begin
      o_y = 1'b0;
      case (i_op)
         LU_NOR:  o_y = ~(i_a | i_b);
         LU_OR:   o_y =   i_a | i_b;
         LU_XNOR: o_y = ~(i_a ^ i_b);
         default: o_y =   i_a ^ i_b;
      endcase
   end

endmodule

// File: rtl/lu_serial_arbiter.sv
// Round-robin sequencer sharing one bit-serial logic cell between two requesters.
// Define LU_PARALLEL_EN to compute the whole word in one cycle with WIDTH cells.
//
//  state   | meaning
//  IDLE    | arbitrate, accept one request
//  RUN     | shift one result bit per cycle (serial build only)
//  DONE    | hold response until rsp_ready
module lu_serial_arbiter
   import lu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                clk,
   input  logic                reset,
   lu_serial_arbiter_if.slave  bus
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_result;
   logic             r_id;
   logic             r_last;
   logic             w_idle;
   logic             w_rdy0;
   logic             w_rdy1;
   logic             w_acc;
   logic             w_run_last;

   assign w_idle = (r_state == ST_IDLE);
   // Ready is masked during reset so nothing looks accepted while the FSM is held.
   assign w_rdy0 = w_idle & ~reset & bus.req0_valid & (~bus.req1_valid |  r_last);
   assign w_rdy1 = w_idle & ~reset & bus.req1_valid & (~bus.req0_valid | ~r_last);
   assign w_acc  = w_rdy0 | w_rdy1;

`ifdef LU_PARALLEL_EN
   localparam state_t ST_AFTER_ACC = ST_DONE;

   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;
   logic [1:0]       w_op;
   logic [WIDTH-1:0] w_word;

   assign w_a        = w_rdy1 ? bus.req1_a  : bus.req0_a;
   assign w_b        = w_rdy1 ? bus.req1_b  : bus.req0_b;
   assign w_op       = w_rdy1 ? bus.req1_op : bus.req0_op;
   assign w_run_last = 1'b1;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      lu_bit_cell u_cell (
         .i_a  (w_a[gi]),
         .i_b  (w_b[gi]),
         .i_op (w_op),
         .o_y  (w_word[gi])
      );
   end
`else
   localparam state_t ST_AFTER_ACC = ST_RUN;
   localparam int     CW           = $clog2(WIDTH);

   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [1:0]       r_op;
   logic             w_bit;

   assign w_run_last = (r_cnt == CW'(WIDTH - 1));

   lu_bit_cell u_cell (
      .i_a  (r_a[r_cnt]),
      .i_b  (r_b[r_cnt]),
      .i_op (r_op),
      .o_y  (w_bit)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_a   <= '0;
         r_b   <= '0;
         r_op  <= LU_NOR;
         r_cnt <= '0;
      end else if (w_acc) begin
         r_a   <= w_rdy1 ? bus.req1_a  : bus.req0_a;
         r_b   <= w_rdy1 ? bus.req1_b  : bus.req0_b;
         r_op  <= w_rdy1 ? bus.req1_op : bus.req0_op;
         r_cnt <= '0;
      end else if (r_state == ST_RUN) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end
`endif

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_acc)         w_state_nxt = ST_AFTER_ACC;
         ST_RUN:  if (w_run_last)    w_state_nxt = ST_DONE;
         ST_DONE: if (bus.rsp_ready) w_state_nxt = ST_IDLE;
         default:                    w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_result <= '0;
         r_id     <= 1'b0;
         r_last   <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            ST_IDLE: if (w_acc) begin
               r_id     <= w_rdy1;
`ifdef LU_PARALLEL_EN
               r_result <= w_word;
`endif
            end
`ifndef LU_PARALLEL_EN
            ST_RUN:  r_result <= {w_bit, r_result[WIDTH-1:1]};
`endif
            ST_DONE: if (bus.rsp_ready) r_last <= r_id;
            default: ;
         endcase
      end
   end

   assign bus.req0_ready = w_rdy0;
   assign bus.req1_ready = w_rdy1;
   assign bus.rsp_valid  = (r_state == ST_DONE);
   assign bus.rsp_data   = r_result;
   assign bus.rsp_id     = r_id;
   assign bus.busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_lu_serial_arbiter.sv
// Directed and randomized checks of lu_serial_arbiter against a word-level model.
module tb_lu_serial_arbiter;

   localparam int W = 8;
`ifdef LU_PARALLEL_EN
   localparam int LAT = 1;
`else
   localparam int LAT = W + 1;
`endif

   logic clk;
   logic reset;
   int   total;
   int   bad;
   bit   m_last;

   lu_serial_arbiter_if #(.WIDTH(W)) bus ();

   lu_serial_arbiter #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [1:0] op);
      case (op)
         2'b00:   return ~(a | b);
         2'b01:   return a | b;
         2'b10:   return ~(a ^ b);
         default: return a ^ b;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic txn(input bit v0, input bit v1,
                      input logic [W-1:0] a0, input logic [W-1:0] b0, input logic [1:0] op0,
                      input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [1:0] op1,
                      input int hold, input bit raise1);
      int             g;
      int             n;
      logic [W-1:0]   exp;
      bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_op = op0;
      bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_op = op1;
      #1;
      g   = (v0 && v1) ? (m_last ? 0 : 1) : (v1 ? 1 : 0);
      exp = (g == 1) ? model(a1, b1, op1) : model(a0, b0, op0);
      chk("grant_rdy0", 32'(bus.req0_ready), 32'(g == 0));
      chk("grant_rdy1", 32'(bus.req1_ready), 32'(g == 1));
      step();
      // Scramble the granted requester's inputs; the running op must not see them.
      if (g == 0) begin
         bus.req0_valid = 1'b0; bus.req0_a = W'($urandom); bus.req0_b = W'($urandom);
         bus.req0_op = 2'($urandom);
      end else begin
         bus.req1_valid = 1'b0; bus.req1_a = W'($urandom); bus.req1_b = W'($urandom);
         bus.req1_op = 2'($urandom);
      end
      if (raise1) bus.req1_valid = 1'b1;
      n = 1;
      while (!bus.rsp_valid && n < 40) begin
         chk("run_busy", 32'(bus.busy), 32'd1);
         chk("run_rdy", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
         step();
         n++;
      end
      chk("latency", 32'(n), 32'(LAT));
      chk("rsp_data", 32'(bus.rsp_data), 32'(exp));
      chk("rsp_id", 32'(bus.rsp_id), 32'(g));
      for (int i = 0; i < hold; i++) begin
         chk("hold_data", 32'(bus.rsp_data), 32'(exp));
         chk("hold_busy", 32'(bus.busy), 32'd1);
         chk("hold_rdy", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
         chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
         step();
      end
      bus.rsp_ready = 1'b1;
      #1;
      chk("hs_rdy", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
      chk("hs_valid", 32'(bus.rsp_valid), 32'd1);
      step();
      bus.rsp_ready = 1'b0;
      m_last = (g == 1);
      chk("post_valid", 32'(bus.rsp_valid), 32'd0);
      chk("post_busy", 32'(bus.busy), 32'd0);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      bus.req0_valid = 1'b1; bus.req0_a = W'($urandom); bus.req0_b = W'($urandom);
      bus.req0_op = 2'($urandom);
      bus.req1_valid = 1'b1; bus.req1_a = W'($urandom); bus.req1_b = W'($urandom);
      bus.req1_op = 2'($urandom);
      bus.rsp_ready = 1'($urandom);
      repeat (3) @(negedge clk);
      chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_data", 32'(bus.rsp_data), 32'd0);
      chk("rst_id", 32'(bus.rsp_id), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_rdy0", 32'(bus.req0_ready), 32'd0);
      chk("rst_rdy1", 32'(bus.req1_ready), 32'd0);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.rsp_ready  = 1'b0;
      reset  = 1'b0;
      m_last = 1'b1;
      step();

      // First tie after reset goes to requester 0, then requester 1 is served.
      txn(1, 1, 8'hF0, 8'h0F, 2'b11, 8'hFF, 8'hFF, 2'b00, 0, 0);
      txn(0, 1, W'($urandom), W'($urandom), 2'($urandom), 8'hFF, 8'hFF, 2'b00, 0, 0);
      txn(1, 1, W'($urandom), W'($urandom), 2'($urandom),
          W'($urandom), W'($urandom), 2'($urandom), 1, 0);
      txn(0, 1, W'($urandom), W'($urandom), 2'($urandom),
          bus.req1_a, bus.req1_b, bus.req1_op, 0, 0);

      txn(1, 0, 8'hA5, 8'h0F, 2'b01, W'($urandom), W'($urandom), 2'($urandom), 0, 0);

      // Backpressure with requester 1 waiting throughout.
      txn(1, 0, 8'h3C, 8'h3C, 2'b10, W'($urandom), W'($urandom), 2'($urandom), 5, 1);
      txn(0, 1, W'($urandom), W'($urandom), 2'($urandom),
          bus.req1_a, bus.req1_b, bus.req1_op, 0, 0);

      for (int k = 0; k < 8; k++) begin
         bit v0;
         bit v1;
         v0 = 1'($urandom_range(0, 1));
         v1 = 1'($urandom_range(0, 1));
         if (!v0 && !v1) v0 = 1'b1;
         txn(v0, v1, W'($urandom), W'($urandom), 2'($urandom),
             W'($urandom), W'($urandom), 2'($urandom), int'($urandom_range(0, 3)), 0);
      end

      // Reset in the middle of an OR op.
      bus.req0_valid = 1'b1; bus.req0_a = W'($urandom); bus.req0_b = W'($urandom);
      bus.req0_op = 2'b01;
      bus.req1_valid = 1'b0;
      #1;
      chk("mid_acc_rdy0", 32'(bus.req0_ready), 32'd1);
      step();
      bus.req0_valid = 1'b0;
`ifndef LU_PARALLEL_EN
      repeat (3) step();
      chk("mid_valid_pre", 32'(bus.rsp_valid), 32'd0);
`endif
      chk("mid_busy_pre", 32'(bus.busy), 32'd1);
      reset = 1'b1;
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
      chk("mid_rst_busy", 32'(bus.busy), 32'd0);
      chk("mid_rst_data", 32'(bus.rsp_data), 32'd0);
      chk("mid_rst_rdy", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
      step();
      step();
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      reset  = 1'b0;
      m_last = 1'b1;
      for (int i = 0; i < W + 3; i++) begin
         step();
         chk("mid_no_rsp", 32'(bus.rsp_valid), 32'd0);
      end
      txn(0, 1, W'($urandom), W'($urandom), 2'($urandom), 8'h00, 8'h00, 2'b00, 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
